// File: rtl/fpu_result_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_result_arbiter
//
// Purpose:
//   Two FPU writeback sources share the single CORE-V-XIF result interface:
//     - EX: the arithmetic pipeline
//     - LS: the load path
//   A round-robin arbiter picks one source. The winner's payload goes into a
//   one-entry output register, which drives result_* under valid/ready rules.
//
// Ports:
//   ck, rst                    clock (rising edge), async active-low reset
//   enable                     0 blocks new grants; the output register can still drain
//   ex_valid/ex_ready          EX source handshake
//   ex_id/ex_data/ex_rd/ex_we  EX payload
//   ls_valid/ls_ready          LS source handshake
//   ls_id/ls_data/ls_rd/ls_we  LS payload
//   result_valid/result_ready  XIF result handshake
//   result_id/data/rd/we       registered result payload
//
// Round-robin pointer (last_grant):
//   state  | meaning
//   SRC_EX | EX won the most recent grant; LS wins the next contention
//   SRC_LS | LS won the most recent grant (or reset); EX wins the next contention
// ---------------------------------------------------------------------------
module fpu_result_arbiter #(
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  enable,

    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [X_ID_WIDTH-1:0] ex_id,
    input  logic [FLEN-1:0]       ex_data,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_we,

    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic [X_ID_WIDTH-1:0] ls_id,
    input  logic [FLEN-1:0]       ls_data,
    input  logic [4:0]            ls_rd,
    input  logic                  ls_we,

    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [X_ID_WIDTH-1:0] result_id,
    output logic [FLEN-1:0]       result_data,
    output logic [4:0]            result_rd,
    output logic                  result_we
);

    typedef enum logic {
        SRC_EX = 1'b0,
        SRC_LS = 1'b1
    } src_t;

    src_t last_grant;

    logic can_load;
    logic grant_ex;
    logic grant_ls;

    // The output register may take a new entry when it is empty, or when it
    // drains in this same cycle. The same-cycle drain gives back-to-back
    // results with no bubble.
    assign can_load = enable && (!result_valid || result_ready);

    always_comb begin
        grant_ex = 1'b0;
        grant_ls = 1'b0;
        if (can_load) begin
            if (ex_valid && ls_valid) begin
                // On contention, the source that did not win last time wins now.
                grant_ex = (last_grant == SRC_LS);
                grant_ls = (last_grant == SRC_EX);
            end else begin
                grant_ex = ex_valid;
                grant_ls = ls_valid;
            end
        end
    end

    // The readys are gated by the raw reset. A source therefore never sees
    // a handshake while reset is held, even if it presents valid throughout.
    assign ex_ready = rst && grant_ex;
    assign ls_ready = rst && grant_ls;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            result_valid <= 1'b0;
            result_id    <= '0;
            result_data  <= '0;
            result_rd    <= '0;
            result_we    <= 1'b0;
            last_grant   <= SRC_LS;
        end else if (grant_ex) begin
            result_valid <= 1'b1;
            result_id    <= ex_id;
            result_data  <= ex_data;
            result_rd    <= ex_rd;
            result_we    <= ex_we;
            last_grant   <= SRC_EX;
        end else if (grant_ls) begin
            result_valid <= 1'b1;
            result_id    <= ls_id;
            result_data  <= ls_data;
            result_rd    <= ls_rd;
            result_we    <= ls_we;
            last_grant   <= SRC_LS;
        end else if (result_valid && result_ready) begin
            // A drain with nothing to replace the entry. The payload is left
            // as is, since it is don't-care once valid drops.
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_result_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_result_arbiter
//
// Directed bench for fpu_result_arbiter. Each expected value is
// hand-computed from the arbitration rules.
//
// Timing:
//   - Inputs are driven 1 ns after the rising edge.
//   - Combinational readys are sampled 1 ns later.
//   - Registered outputs are sampled 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_fpu_result_arbiter;

    localparam int X_ID_WIDTH = 4;
    localparam int FLEN       = 32;

    logic                  ck;
    logic                  rst;
    logic                  enable;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [X_ID_WIDTH-1:0] ex_id;
    logic [FLEN-1:0]       ex_data;
    logic [4:0]            ex_rd;
    logic                  ex_we;
    logic                  ls_valid;
    logic                  ls_ready;
    logic [X_ID_WIDTH-1:0] ls_id;
    logic [FLEN-1:0]       ls_data;
    logic [4:0]            ls_rd;
    logic                  ls_we;
    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [FLEN-1:0]       result_data;
    logic [4:0]            result_rd;
    logic                  result_we;

    int n_vec;
    int n_miss;

    fpu_result_arbiter #(
        .X_ID_WIDTH(X_ID_WIDTH),
        .FLEN      (FLEN)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .enable      (enable),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_id       (ex_id),
        .ex_data     (ex_data),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ls_valid    (ls_valid),
        .ls_ready    (ls_ready),
        .ls_id       (ls_id),
        .ls_data     (ls_data),
        .ls_rd       (ls_rd),
        .ls_we       (ls_we),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_id   (result_id),
        .result_data (result_data),
        .result_rd   (result_rd),
        .result_we   (result_we)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    logic [3:0] exp_seq [4];
    logic       exr;
    logic       lsr;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        exp_seq[0] = 4'd1;
        exp_seq[1] = 4'd9;
        exp_seq[2] = 4'd2;
        exp_seq[3] = 4'd10;

        // Hold reset while EX presents id 3.
        rst          = 1'b0;
        enable       = 1'b1;
        ex_valid     = 1'b1;
        ex_id        = 4'd3;
        ex_data      = 32'h0000_0003;
        ex_rd        = 5'd3;
        ex_we        = 1'b1;
        ls_valid     = 1'b0;
        ls_id        = 4'd0;
        ls_data      = 32'h0;
        ls_rd        = 5'd0;
        ls_we        = 1'b0;
        result_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid",    32'(result_valid), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready),     32'd0);
        chk("rst_ls_ready", 32'(ls_ready),     32'd0);
        chk("rst_data",     32'(result_data),  32'd0);

        // Release reset. EX wins on the first edge.
        rst = 1'b1;
        #1;
        chk("rel_ex_ready", 32'(ex_ready), 32'd1);
        step();
        chk("first_valid", 32'(result_valid), 32'd1);
        chk("first_id",    32'(result_id),    32'd3);

        // Drain with no new source.
        ex_valid     = 1'b0;
        result_ready = 1'b1;
        #1;
        chk("drain_ex_ready", 32'(ex_ready), 32'd0);
        step();
        chk("drain_valid", 32'(result_valid), 32'd0);

        // LS alone: ready in the same cycle, loaded on the next edge.
        ls_valid = 1'b1;
        ls_id    = 4'd7;
        ls_rd    = 5'd12;
        ls_we    = 1'b1;
        ls_data  = 32'hA5A5_0007;
        #1;
        chk("ls_only_ls_ready", 32'(ls_ready), 32'd1);
        chk("ls_only_ex_ready", 32'(ex_ready), 32'd0);
        step();
        chk("ls_only_valid", 32'(result_valid), 32'd1);
        chk("ls_only_id",    32'(result_id),    32'd7);
        chk("ls_only_rd",    32'(result_rd),    32'd12);
        chk("ls_only_we",    32'(result_we),    32'd1);
        chk("ls_only_data",  32'(result_data),  32'hA5A5_0007);

        // Continuous contention after an LS grant: EX, LS, EX, LS with no gaps.
        ex_valid = 1'b1;
        ex_id    = 4'd1;
        ex_we    = 1'b0;
        ls_id    = 4'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            exr = ex_ready;
            lsr = ls_ready;
            chk("rr_one_ready", 32'(exr ^ lsr), 32'd1);
            step();
            chk("rr_valid", 32'(result_valid), 32'd1);
            chk("rr_id",    32'(result_id),    32'(exp_seq[i]));
            if (exr) ex_id = ex_id + 4'd1;
            if (lsr) ls_id = ls_id + 4'd1;
        end

        // Stall: load id 5 from EX alone, then hold result_ready low.
        ls_valid = 1'b0;
        ex_id    = 4'd5;
        ex_data  = 32'h3F80_0000;
        ex_rd    = 5'd5;
        step();
        chk("stall_load_id", 32'(result_id), 32'd5);
        result_ready = 1'b0;
        ex_id        = 4'd6;
        ex_data      = 32'h4000_0000;
        ls_valid     = 1'b1;
        ls_id        = 4'd12;
        ls_data      = 32'h0000_000C;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ex_ready", 32'(ex_ready),     32'd0);
            chk("stall_ls_ready", 32'(ls_ready),     32'd0);
            step();
            chk("stall_valid",    32'(result_valid), 32'd1);
            chk("stall_id",       32'(result_id),    32'd5);
            chk("stall_data",     32'(result_data),  32'h3F80_0000);
        end
        // Release: EX won last, so LS is granted and loaded the following cycle.
        result_ready = 1'b1;
        #1;
        chk("unstall_ls_ready", 32'(ls_ready), 32'd1);
        chk("unstall_ex_ready", 32'(ex_ready), 32'd0);
        step();
        chk("unstall_id",   32'(result_id),   32'd12);
        chk("unstall_data", 32'(result_data), 32'h0000_000C);
        ex_valid = 1'b0;
        ls_valid = 1'b0;
        step();
        chk("unstall_drain", 32'(result_valid), 32'd0);

        // enable=0 with both sources valid and the output empty.
        enable   = 1'b0;
        ex_valid = 1'b1;
        ex_id    = 4'd4;
        ls_valid = 1'b1;
        ls_id    = 4'd13;
        #1;
        chk("dis_ex_ready", 32'(ex_ready), 32'd0);
        chk("dis_ls_ready", 32'(ls_ready), 32'd0);
        step();
        step();
        chk("dis_valid", 32'(result_valid), 32'd0);
        // Re-enable: last grant was LS, so EX wins.
        enable = 1'b1;
        #1;
        chk("en_ex_ready", 32'(ex_ready), 32'd1);
        chk("en_ls_ready", 32'(ls_ready), 32'd0);
        step();
        chk("en_id", 32'(result_id), 32'd4);
        // A pending result still drains while enable=0.
        enable = 1'b0;
        step();
        chk("dis_drain_valid", 32'(result_valid), 32'd0);

        // Async reset mid-cycle while a result is stalled.
        enable       = 1'b1;
        ls_valid     = 1'b0;
        ex_id        = 4'd14;
        ex_data      = 32'h1234_5678;
        result_ready = 1'b0;
        step();
        chk("pre_arst_valid", 32'(result_valid), 32'd1);
        chk("pre_arst_data",  32'(result_data),  32'h1234_5678);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",    32'(result_valid), 32'd0);
        chk("arst_data",     32'(result_data),  32'd0);
        chk("arst_ex_ready", 32'(ex_ready),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
